mont_mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one Montgomery multiplier core between two requesters, e.g. two exponentiation engines, or one engine plus a precompute unit for R^2 mod m.
- For each granted job it captures the operands, issues a single-cycle start to the multiplier, waits for the multiplier's done, returns the result, and signals completion to the owner.
- Sits between requesters and the shared multiplier; one job is in flight at a time.

---
 rtl/mont_mul_arbiter.sv | 120 ++++++++++++
 tb/tb_mont_mul_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one Montgomery multiplier
// between two requesters; one job in flight at a time.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req{0,1}_valid/a/b/m  job request and operands from each requester
//   req{0,1}_ready        one-cycle pulse: job accepted
//   req{0,1}_done         one-cycle pulse: rsp_result holds this job's result
//   rsp_result            result of the last completed job
//   mul_start/a/b/m       start pulse and registered operands to the multiplier
//   mul_done/mul_result   completion and result from the multiplier
//   busy                  high whenever a job is being sequenced
module mont_mul_arbiter #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req0_m,
    output logic             req0_ready,
    output logic             req0_done,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] req1_m,
    output logic             req1_ready,
    output logic             req1_done,
    output logic [WIDTH-1:0] rsp_result,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_m,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_result,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    logic   grant_id;
    logic   last_grant;
    logic   any_valid;
    logic   pick;

    // On contention the requester that was not served last wins;
    // otherwise whichever single requester is valid.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        pick      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            mul_start  <= 1'b0;
            busy       <= 1'b0;
            rsp_result <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_m      <= '0;
        end else begin
            // Pulse outputs default low; each is raised for one state only.
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            mul_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id   <= pick;
                        mul_a      <= pick ? req1_a : req0_a;
                        mul_b      <= pick ? req1_b : req0_b;
                        mul_m      <= pick ? req1_m : req0_m;
                        mul_start  <= 1'b1;
                        req0_ready <= ~pick;
                        req1_ready <= pick;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        rsp_result <= mul_result;
                        req0_done  <= ~grant_id;
                        req1_done  <= grant_id;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed bench for mont_mul_arbiter with a 6-cycle multiplier model.
// Ports: none (top-level bench).
module tb_mont_mul_arbiter;

    localparam int WIDTH = 512;
    localparam int BUDGET = 60;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic [WIDTH-1:0] req0_m = '0;
    logic             req0_ready;
    logic             req0_done;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic [WIDTH-1:0] req1_m = '0;
    logic             req1_ready;
    logic             req1_done;
    logic [WIDTH-1:0] rsp_result;
    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_m;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;
    logic             busy;

    logic             spur = 1'b0;
    logic             mdl_done = 1'b0;
    logic [WIDTH-1:0] mdl_res = '0;
    logic [WIDTH-1:0] ma = '0;
    logic [WIDTH-1:0] mb = '0;
    logic [WIDTH-1:0] mm = '0;
    int               cnt = 0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;
    int mdl_cnt = 0;
    int grants[$];

    always #5 clk = ~clk;

    assign mul_done   = mdl_done | spur;
    assign mul_result = spur ? WIDTH'('hDEAD) : mdl_res;

    mont_mul_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_m     (req0_m),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_m     (req1_m),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .rsp_result (rsp_result),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_m      (mul_m),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .busy       (busy)
    );

    // Multiplier model: done exactly 6 edges after it samples start.
    // It ignores the arbiter reset, so it can finish an aborted job.
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (mul_start) begin
            cnt <= 6;
            ma  <= mul_a;
            mb  <= mul_b;
            mm  <= mul_m;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                mdl_done <= 1'b1;
                mdl_res  <= (mm == '0) ? '0 : (ma * mb) % mm;
            end
        end
    end

    task automatic check(input string tag,
                         input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse bookkeeping and per-cycle exclusivity of ready/done/start.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (mul_start) start_cnt++;
            if (mdl_done) mdl_cnt++;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (req0_done) done0_cnt++;
            if (req1_done) done1_cnt++;
            check("excl",
                  WIDTH'((req0_ready & req1_ready) |
                         (req0_done & req1_done) |
                         ((req0_ready | req1_ready) &
                          (req0_done | req1_done))),
                  '0);
        end
    end

    // sel: 0 ready0, 1 ready1, 2 done0, 3 done1. Waits on negedges.
    task automatic wait_sig(input int sel, output int n);
        logic v;
        logic prev_md;
        n = 0;
        prev_md = mul_done;
        v = 1'b0;
        while (!v && n < BUDGET) begin
            prev_md = mul_done;
            @(negedge clk);
            n++;
            case (sel)
                0: v = req0_ready;
                1: v = req1_ready;
                2: v = req0_done;
                default: v = req1_done;
            endcase
        end
        check("wait_timeout", WIDTH'(v), 1);
        if (sel >= 2) check("done_lat", WIDTH'(prev_md), 1);
    endtask

    initial begin
        int n;
        int s0;
        int d0;
        int d1;
        int dones;
        int raised;

        // Reset then idle.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", WIDTH'(busy), 0);
        check("rst_start", WIDTH'(mul_start), 0);
        check("rst_rsp", rsp_result, 0);
        check("rst_mula", mul_a, 0);
        check("rst_mulm", mul_m, 0);
        check("rst_pulses",
              WIDTH'({req0_ready, req1_ready, req0_done, req1_done}), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", WIDTH'(busy), 0);
        check("idle_starts", start_cnt, 0);

        // Single job on requester 0.
        req0_a = 7; req0_b = 9; req0_m = 11;
        req0_valid = 1'b1;
        wait_sig(0, n);
        check("rdy_lat", n, 1);
        check("start_w_rdy", WIDTH'(mul_start), 1);
        check("mul_a", mul_a, 7);
        check("mul_m", mul_m, 11);
        req0_valid = 1'b0;
        d1 = done1_cnt;
        wait_sig(2, n);
        check("single_rsp", rsp_result, 8);
        check("single_busy", WIDTH'(busy), 1);
        @(negedge clk);
        check("single_d1", done1_cnt - d1, 0);
        check("single_idle", WIDTH'(busy), 0);

        // Contention right after reset: requester 0 first.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        s0 = start_cnt;
        req0_a = 3; req0_b = 5; req0_m = 7;
        req1_a = 4; req1_b = 4; req1_m = 7;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("cont_rdy0", WIDTH'(req0_ready), 1);
        check("cont_rdy1", WIDTH'(req1_ready), 0);
        req0_valid = 1'b0;
        wait_sig(2, n);
        check("cont_rsp0", rsp_result, 1);
        wait_sig(1, n);
        req1_valid = 1'b0;
        check("cont_mulb", mul_b, 4);
        wait_sig(3, n);
        check("cont_rsp1", rsp_result, 2);
        check("cont_starts", start_cnt - s0, 2);
        @(negedge clk);

        // Continuous contention for 6 jobs.
        grants.delete();
        dones = 0;
        raised = 2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        while (dones < 6 && n < 600) begin
            @(negedge clk);
            n++;
            if (req0_ready) req0_valid = 1'b0;
            if (req1_ready) req1_valid = 1'b0;
            if (req0_done) begin
                dones++;
                check("rr_rsp0", rsp_result, 1);
                if (raised < 6) begin
                    req0_valid = 1'b1;
                    raised++;
                end
            end
            if (req1_done) begin
                dones++;
                check("rr_rsp1", rsp_result, 2);
                if (raised < 6) begin
                    req1_valid = 1'b1;
                    raised++;
                end
            end
        end
        check("rr_dones", dones, 6);
        check("rr_grants", grants.size(), 6);
        for (int i = 0; i < grants.size() && i < 6; i++)
            check("rr_order", grants[i], i % 2);
        @(negedge clk);

        // Reset in WAIT aborts the job; late mul_done is ignored.
        req0_a = 7; req0_b = 9; req0_m = 11;
        req0_valid = 1'b1;
        wait_sig(0, n);
        req0_valid = 1'b0;
        d0 = done0_cnt + done1_cnt;
        s0 = mdl_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", WIDTH'(busy), 0);
        check("abort_mula", mul_a, 0);
        repeat (12) @(negedge clk);
        check("abort_mdl", mdl_cnt - s0, 1);
        check("abort_nodone", (done0_cnt + done1_cnt) - d0, 0);
        check("abort_rsp", rsp_result, 0);
        check("abort_idle", WIDTH'(busy), 0);
        req1_a = 4; req1_b = 4; req1_m = 7;
        req1_valid = 1'b1;
        wait_sig(1, n);
        req1_valid = 1'b0;
        check("post_rdy_lat", n, 1);
        wait_sig(3, n);
        check("post_rsp", rsp_result, 2);
        @(negedge clk);

        // Spurious mul_done while idle.
        req0_a = 7; req0_b = 9; req0_m = 11;
        req0_valid = 1'b1;
        wait_sig(0, n);
        req0_valid = 1'b0;
        wait_sig(2, n);
        repeat (2) @(negedge clk);
        d0 = done0_cnt + done1_cnt;
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        check("spur_busy", WIDTH'(busy), 0);
        @(negedge clk);
        check("spur_rsp", rsp_result, 8);
        check("spur_nodone", (done0_cnt + done1_cnt) - d0, 0);
        check("spur_idle", WIDTH'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
